rr_capture_arbiter: RTL and testbench

- Shares one DATA_W-bit capture register (D flip-flop bank, q/rstn style) between N requesters.
- Uses round-robin priority with optional burst lock.
- Each accepted request is captured into the shared register and presented downstream with a valid/ready handshake.
- Sits between several producer blocks and a single consumer that needs one registered data source.

---
 rtl/rr_capture_arbiter_pkg.sv | 18 +
 rtl/rr_capture_arbiter_pick.sv | 31 +++
 rtl/rr_capture_arbiter.sv | 95 +++++++++
 tb/tb_rr_capture_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_capture_arbiter_pkg.sv
// rr_capture_arbiter_pkg: shared types, defaults and helpers for the capture arbiter
package rr_capture_arbiter_pkg;

    typedef enum logic {EMPTY, FULL} state_t;

    localparam int DEF_N         = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 4;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_capture_arbiter_pick.sv
// rr_pick: combinational round-robin search for the first request at or above a pointer
module rr_pick #(
    parameter int N     = 4,
    parameter int SRC_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [SRC_W-1:0] i_ptr,
    output logic [N-1:0]     o_onehot,
    output logic [SRC_W-1:0] o_idx
);

    // Walk upward from the pointer, wrapping at N-1, and keep the first hit.
    always_comb begin : search
        int   j;
        logic found;
        o_onehot = '0;
        o_idx    = '0;
        found    = 1'b0;
        j        = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(i_ptr) + k;
            if (j >= N) j = j - N;
            if (!found && i_req[j]) begin
                found       = 1'b1;
                o_idx       = SRC_W'(j);
                o_onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_capture_arbiter.sv
// rr_capture_arbiter: round-robin arbiter with burst lock feeding one shared capture register
module rr_capture_arbiter
    import rr_capture_arbiter_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int SRC_W     = 2
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [N-1:0]      i_req,
    input  logic [N-1:0]      i_lock,
    input  logic [N*DATA_W-1:0] i_req_data,
    output logic [N-1:0]      o_gnt,
    output logic [DATA_W-1:0] o_q,
    output logic [SRC_W-1:0]  o_q_src,
    output logic              o_q_valid,
    input  logic              i_q_ready
);

    localparam int CNT_W = clog2(MAX_BURST + 1);

    state_t            r_state;
    logic [DATA_W-1:0] r_q;
    logic [SRC_W-1:0]  r_src;
    logic [N-1:0]      r_gnt;
    logic [SRC_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic [SRC_W-1:0]  r_owner;
    logic              r_owner_vld;

    logic [N-1:0]      w_pick_oh;
    logic [SRC_W-1:0]  w_pick_idx;
    logic              w_load;
    logic              w_lock_hit;
    logic [SRC_W-1:0]  w_win;
    logic [N-1:0]      w_win_oh;
    logic [SRC_W-1:0]  w_ptr_nxt;

    rr_pick #(.N(N), .SRC_W(SRC_W)) u_pick (
        .i_req    (i_req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx)
    );

    // Capture when someone asks and the register is free or being drained this cycle;
    // the owner keeps priority while locked and under its burst budget.
    always_comb begin
        w_load     = (|i_req) && (r_state == EMPTY || i_q_ready);
        w_lock_hit = r_owner_vld && i_req[r_owner] && i_lock[r_owner]
                     && (r_cnt < CNT_W'(MAX_BURST));
        w_win      = w_lock_hit ? r_owner : w_pick_idx;
        w_win_oh   = w_lock_hit ? (N'(1) << r_owner) : w_pick_oh;
        w_ptr_nxt  = (w_win == SRC_W'(N - 1)) ? '0 : w_win + 1'b1;
    end

    // FSM plus capture register, grant pulse, pointer and burst tracking.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= EMPTY;
            r_q         <= '0;
            r_src       <= '0;
            r_gnt       <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_owner     <= '0;
            r_owner_vld <= 1'b0;
        end else begin
            r_gnt <= w_load ? w_win_oh : '0;
            if (w_load) begin
                r_state <= FULL;
                r_q     <= i_req_data[int'(w_win)*DATA_W +: DATA_W];
                r_src   <= w_win;
                r_ptr   <= w_ptr_nxt;
                if (w_lock_hit) begin
                    r_cnt <= r_cnt + 1'b1;
                end else begin
                    r_cnt       <= CNT_W'(1);
                    r_owner     <= w_win;
                    r_owner_vld <= 1'b1;
                end
            end else if (r_state == FULL && i_q_ready) begin
                r_state <= EMPTY;
            end
        end
    end

    assign o_q       = r_q;
    assign o_q_src   = r_src;
    assign o_q_valid = (r_state == FULL);
    assign o_gnt     = r_gnt;

endmodule

// File: tb/tb_rr_capture_arbiter.sv
// tb_rr_capture_arbiter: directed self-checking bench for rr_capture_arbiter
module tb_rr_capture_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic [1:0]  q_src;
    logic        q_valid;
    logic        q_ready;

    int n_tests = 0;
    int n_fail  = 0;

    rr_capture_arbiter #(.N(4), .DATA_W(8), .MAX_BURST(4), .SRC_W(2)) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_req      (req),
        .i_lock     (lock),
        .i_req_data (req_data),
        .o_gnt      (gnt),
        .o_q        (q),
        .o_q_src    (q_src),
        .o_q_valid  (q_valid),
        .i_q_ready  (q_ready)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req     = '0;
        lock    = '0;
        q_ready = 1'b0;
        rstn    = 1'b0;
        #2;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        rstn = 1'b0;
        #1;
        n_tests++; if (q !== 8'h00)   begin n_fail++; $display("FAIL reset_q got=%h exp=00", q); end
        n_tests++; if (q_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", q_valid); end
        n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        n_tests++; if (q_src !== 2'd0) begin n_fail++; $display("FAIL reset_src got=%0d exp=0", q_src); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset_mid;
        do_reset();
        req_data = 32'h0000_00A5;
        req = 4'b0001;
        tick();
        n_tests++; if (q !== 8'hA5 || q_valid !== 1'b1) begin n_fail++; $display("FAIL mid_fill got q=%h v=%b exp q=a5 v=1", q, q_valid); end
        req = 4'b0000;
        #3;
        rstn = 1'b0;
        #1;
        n_tests++; if (q !== 8'h00 || q_valid !== 1'b0 || gnt !== 4'b0000)
            begin n_fail++; $display("FAIL mid_async got q=%h v=%b g=%b exp 00/0/0000", q, q_valid, gnt); end
        @(negedge clk);
        rstn = 1'b1;
        req = 4'b0001;
        tick();
        n_tests++; if (gnt !== 4'b0001 || q_src !== 2'd0 || q_valid !== 1'b1)
            begin n_fail++; $display("FAIL mid_after got g=%b src=%0d v=%b exp 0001/0/1", gnt, q_src, q_valid); end
        req = 4'b0000;
        q_ready = 1'b1;
        tick();
    endtask

    task automatic test_round_robin;
        do_reset();
        req_data = 32'h1312_1110;
        req = 4'b1111;
        q_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_tests++;
            if (q_src !== 2'(k % 4) || q !== 8'(8'h10 + k % 4) || gnt !== 4'(1 << (k % 4)) || q_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_%0d got src=%0d q=%h g=%b v=%b exp src=%0d q=%h g=%b v=1",
                         k, q_src, q, gnt, q_valid, k % 4, 8'h10 + k % 4, 4'(1 << (k % 4)));
            end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_burst;
        logic [1:0] exp_src [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        do_reset();
        req_data = 32'h4444_2211;
        req = 4'b0011;
        lock = 4'b0001;
        q_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_tests++;
            if (q_src !== exp_src[k] || gnt !== 4'(1 << exp_src[k])) begin
                n_fail++;
                $display("FAIL burst_%0d got src=%0d g=%b exp src=%0d", k, q_src, gnt, exp_src[k]);
            end
        end
        req = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_tests++;
            if (q_src !== 2'd0 || gnt !== 4'b0001) begin
                n_fail++;
                $display("FAIL burst_alone_%0d got src=%0d g=%b exp src=0 g=0001", k, q_src, gnt);
            end
        end
        req = 4'b0000;
        lock = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure;
        do_reset();
        req_data = 32'h553C_2211;
        req = 4'b0100;
        tick();
        n_tests++; if (q !== 8'h3C || q_src !== 2'd2 || gnt !== 4'b0100)
            begin n_fail++; $display("FAIL bp_fill got q=%h src=%0d g=%b exp 3c/2/0100", q, q_src, gnt); end
        req = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_tests++;
            if (q !== 8'h3C || q_src !== 2'd2 || q_valid !== 1'b1 || gnt !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_stall_%0d got q=%h src=%0d v=%b g=%b exp 3c/2/1/0000", k, q, q_src, q_valid, gnt);
            end
        end
        q_ready = 1'b1;
        tick();
        n_tests++; if (q_src !== 2'd3 || q !== 8'h55 || gnt !== 4'b1000)
            begin n_fail++; $display("FAIL bp_release got src=%0d q=%h g=%b exp 3/55/1000", q_src, q, gnt); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_drain;
        do_reset();
        req_data = 32'h0077_0000;
        req = 4'b0100;
        tick();
        n_tests++; if (gnt !== 4'b0100 || q !== 8'h77)
            begin n_fail++; $display("FAIL drain_cap got g=%b q=%h exp 0100/77", gnt, q); end
        req = 4'b0000;
        q_ready = 1'b1;
        tick();
        n_tests++; if (q_valid !== 1'b0 || q !== 8'h77 || q_src !== 2'd2 || gnt !== 4'b0000)
            begin n_fail++; $display("FAIL drain_empty got v=%b q=%h src=%0d g=%b exp 0/77/2/0000", q_valid, q, q_src, gnt); end
        tick();
        n_tests++; if (q_valid !== 1'b0)
            begin n_fail++; $display("FAIL drain_idle got v=%b exp 0", q_valid); end
    endtask

    task automatic test_wrap;
        do_reset();
        req_data = 32'h00A2_00A0;
        req = 4'b0100;
        tick();
        req = 4'b0000;
        q_ready = 1'b1;
        tick();
        req = 4'b0101;
        tick();
        n_tests++; if (q_src !== 2'd0 || q !== 8'hA0 || gnt !== 4'b0001)
            begin n_fail++; $display("FAIL wrap_first got src=%0d q=%h g=%b exp 0/a0/0001", q_src, q, gnt); end
        tick();
        n_tests++; if (q_src !== 2'd2 || q !== 8'hA2 || gnt !== 4'b0100)
            begin n_fail++; $display("FAIL wrap_second got src=%0d q=%h g=%b exp 2/a2/0100", q_src, q, gnt); end
        req = 4'b0000;
        tick();
    endtask

    initial begin
        rstn = 1'b0;
        req = '0;
        lock = '0;
        req_data = '0;
        q_ready = 1'b0;
        test_reset();
        test_reset_mid();
        test_round_robin();
        test_burst();
        test_backpressure();
        test_drain();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
